// File: rtl/tlul_device_adapter.sv
// TL-UL device adapter: A-channel to single-cycle word memory, in-order D responses.
// Define TLUL_DEVICE_ADDR_CHECK_EN to reject requests with nonzero upper address bits.
package tlul_pkg;

   localparam logic [2:0] PUT_FULL     = 3'd0;
   localparam logic [2:0] PUT_PARTIAL  = 3'd1;
   localparam logic [2:0] GET          = 3'd4;
   localparam logic [2:0] ACC_ACK      = 3'd0;
   localparam logic [2:0] ACC_ACK_DATA = 3'd1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module tlul_device_adapter
   import tlul_pkg::*;
#(
   parameter int MEM_AW    = 12,
   parameter int RSP_DEPTH = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  tl_h2d_t           tl_d_i,
   output tl_d2h_t           tl_d_o,
   output logic              req_o,
   output logic              we_o,
   output logic [MEM_AW-1:0] addr_o,
   output logic [31:0]       wdata_o,
   output logic [3:0]        be_o,
   input  logic [31:0]       rdata_i,
   input  logic              err_i
);

   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic [2:0]  opcode;
      logic [1:0]  size;
      logic [7:0]  source;
      logic [31:0] data;
      logic        error;
   } rsp_t;

   rsp_t          rsp_q [RSP_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          mem_vld_q;
   logic          mem_get_q;
   logic          mem_bad_q;
   logic [1:0]    mem_size_q;
   logic [7:0]    mem_src_q;

   logic [CW:0]   occ;
   logic          a_ready;
   logic          accept;
   logic          legal;
   logic          is_get;
   logic          op_ok;
   logic          aligned;
   logic          addr_ok;
   logic [3:0]    win;
   logic          push;
   logic          pop;
   rsp_t          push_rsp;
   rsp_t          head;
   logic          unused_a;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign occ     = {1'b0, cnt_q} + (CW+1)'(mem_vld_q);
   assign a_ready = !reset && (occ < (CW+1)'(RSP_DEPTH));
   assign accept  = tl_d_i.a_valid && a_ready;

   assign is_get = (tl_d_i.a_opcode == GET);
   assign op_ok  = (tl_d_i.a_opcode == PUT_FULL) ||
                   (tl_d_i.a_opcode == PUT_PARTIAL) || is_get;

`ifdef TLUL_DEVICE_ADDR_CHECK_EN
   assign addr_ok  = ~|tl_d_i.a_address[31:MEM_AW+2];
   assign unused_a = ^tl_d_i.a_param;
`else
   // Upper bits alias; the crossbar owns address decode.
   assign addr_ok  = 1'b1;
   assign unused_a = ^{tl_d_i.a_param, tl_d_i.a_address[31:MEM_AW+2]};
`endif

   always_comb begin
      win     = 4'h0;
      aligned = 1'b1;
      unique case (tl_d_i.a_size)
         2'd0: win = 4'b0001 << tl_d_i.a_address[1:0];
         2'd1: begin
            win     = 4'b0011 << {tl_d_i.a_address[1], 1'b0};
            aligned = ~tl_d_i.a_address[0];
         end
         2'd2: begin
            win     = 4'b1111;
            aligned = (tl_d_i.a_address[1:0] == 2'b00);
         end
         default: aligned = 1'b0;
      endcase
   end

   assign legal = op_ok && aligned && addr_ok &&
                  ~|(tl_d_i.a_mask & ~win) &&
                  ((tl_d_i.a_opcode != PUT_FULL) || (tl_d_i.a_mask == win));

   assign req_o   = accept && legal;
   assign we_o    = req_o && !is_get;
   assign addr_o  = tl_d_i.a_address[MEM_AW+1:2];
   assign wdata_o = tl_d_i.a_data;
   assign be_o    = tl_d_i.a_mask;

   assign push = mem_vld_q;
   assign pop  = (cnt_q != '0) && tl_d_i.d_ready;
   assign head = rsp_q[rptr_q];

   always_comb begin
      push_rsp        = '0;
      push_rsp.opcode = mem_get_q ? ACC_ACK_DATA : ACC_ACK;
      push_rsp.size   = mem_size_q;
      push_rsp.source = mem_src_q;
      push_rsp.data   = (mem_get_q && !mem_bad_q) ? rdata_i : 32'h0;
      push_rsp.error  = mem_bad_q | err_i;
   end

   always_comb begin
      wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      tl_d_o         = '0;
      tl_d_o.a_ready = a_ready;
      if (cnt_q != '0) begin
         tl_d_o.d_valid  = 1'b1;
         tl_d_o.d_opcode = head.opcode;
         tl_d_o.d_size   = head.size;
         tl_d_o.d_source = head.source;
         tl_d_o.d_data   = head.data;
         tl_d_o.d_error  = head.error;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_vld_q  <= 1'b0;
         mem_get_q  <= 1'b0;
         mem_bad_q  <= 1'b0;
         mem_size_q <= 2'd0;
         mem_src_q  <= 8'd0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            rsp_q[i] <= '0;
         end
      end else begin
         mem_vld_q <= accept;
         if (accept) begin
            mem_get_q  <= is_get;
            mem_bad_q  <= ~legal;
            mem_size_q <= tl_d_i.a_size;
            mem_src_q  <= tl_d_i.a_source;
         end
         if (push) begin
            rsp_q[wptr_q] <= push_rsp;
         end
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_tlul_device_adapter.sv
// Directed bench for tlul_device_adapter with a behavioural one-cycle word memory.
module tb_tlul_device_adapter;
   import tlul_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   tl_h2d_t     h2d;
   tl_d2h_t     d2h;
   logic        req_o;
   logic        we_o;
   logic [11:0] addr_o;
   logic [31:0] wdata_o;
   logic [3:0]  be_o;
   logic [31:0] rdata_i = 32'h0;
   logic        err_i = 1'b0;

   logic [31:0] mem [4096];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [3:0]  mk;
      logic        err;
   } vec_t;

   tlul_device_adapter #(.MEM_AW(12), .RSP_DEPTH(3)) dut (
      .clock   (clock),
      .reset   (reset),
      .tl_d_i  (h2d),
      .tl_d_o  (d2h),
      .req_o   (req_o),
      .we_o    (we_o),
      .addr_o  (addr_o),
      .wdata_o (wdata_o),
      .be_o    (be_o),
      .rdata_i (rdata_i),
      .err_i   (err_i)
   );

   always #5 clock = ~clock;

   // Memory: data one cycle after req_o; the top word reports an error.
   always @(posedge clock) begin
      err_i <= req_o && (addr_o == 12'hFFF);
      if (req_o) begin
         if (we_o) begin
            for (int b = 0; b < 4; b++) begin
               if (be_o[b]) mem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
            end
         end else begin
            rdata_i <= mem[addr_o];
         end
      end
   end

   task automatic drive_a(input logic [2:0] op, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [3:0] mk,
                          input logic [31:0] dt, input logic [7:0] src);
      h2d.a_valid   = 1'b1;
      h2d.a_opcode  = op;
      h2d.a_param   = 3'd0;
      h2d.a_size    = sz;
      h2d.a_source  = src;
      h2d.a_address = ad;
      h2d.a_mask    = mk;
      h2d.a_data    = dt;
   endtask

   task automatic idle_a();
      h2d.a_valid  = 1'b0;
      h2d.a_opcode = 3'd0;
      h2d.a_mask   = 4'h0;
      h2d.a_data   = 32'h0;
   endtask

   task automatic test_reset();
      h2d = '0;
      reset = 1'b1;
      drive_a(GET, 2'd2, 32'h10, 4'hF, 32'h0, 8'd1);
      @(negedge clock); #1;
      checks++;
      if ({req_o, we_o} !== 2'b00) begin
         errors++;
         $display("FAIL reset_req: got %b want 00", {req_o, we_o});
      end
      checks++;
      if (d2h !== '0) begin
         errors++;
         $display("FAIL reset_d2h: got %h want 0", d2h);
      end
      @(negedge clock);
      reset = 1'b0;
      idle_a();
      #1;
      checks++;
      if (d2h.a_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_aready: got %b want 1", d2h.a_ready);
      end
      repeat (3) @(negedge clock);
      #1;
      checks++;
      if (d2h.d_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_rsp: got %b want 0", d2h.d_valid);
      end
   endtask

   task automatic test_get();
      h2d.d_ready = 1'b1;
      @(negedge clock);
      drive_a(GET, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3);
      #1;
      checks++;
      if ({req_o, we_o, addr_o} !== {1'b1, 1'b0, 12'd4}) begin
         errors++;
         $display("FAIL get_req: got %h want %h",
                  {req_o, we_o, addr_o}, {1'b1, 1'b0, 12'd4});
      end
      @(negedge clock);
      idle_a();
      #1;
      checks++;
      if (d2h.d_valid !== 1'b0) begin
         errors++;
         $display("FAIL get_early: got %b want 0", d2h.d_valid);
      end
      @(negedge clock); #1;
      checks++;
      if ({d2h.d_valid, d2h.d_opcode, d2h.d_data, d2h.d_source,
           d2h.d_error, d2h.d_size} !==
          {1'b1, 3'd1, 32'hDEADBEEF, 8'd3, 1'b0, 2'd2}) begin
         errors++;
         $display("FAIL get_rsp: got v%b op%0d d%h s%0d e%b",
                  d2h.d_valid, d2h.d_opcode, d2h.d_data,
                  d2h.d_source, d2h.d_error);
      end
      @(negedge clock); #1;
      checks++;
      if (d2h.d_valid !== 1'b0) begin
         errors++;
         $display("FAIL get_popped: got %b want 0", d2h.d_valid);
      end
   endtask

   task automatic test_put_partial();
      @(negedge clock);
      drive_a(PUT_PARTIAL, 2'd0, 32'h22, 4'h4, 32'h00AB0000, 8'd5);
      #1;
      checks++;
      if ({req_o, we_o, be_o, addr_o} !==
          {1'b1, 1'b1, 4'h4, 12'd8}) begin
         errors++;
         $display("FAIL put_req: got %h want %h",
                  {req_o, we_o, be_o, addr_o}, {1'b1, 1'b1, 4'h4, 12'd8});
      end
      @(negedge clock);
      idle_a();
      @(negedge clock); #1;
      checks++;
      if ({d2h.d_valid, d2h.d_opcode, d2h.d_error, d2h.d_source,
           d2h.d_data} !== {1'b1, 3'd0, 1'b0, 8'd5, 32'h0}) begin
         errors++;
         $display("FAIL put_rsp: got v%b op%0d e%b s%0d d%h",
                  d2h.d_valid, d2h.d_opcode, d2h.d_error,
                  d2h.d_source, d2h.d_data);
      end
      @(negedge clock);
      drive_a(GET, 2'd2, 32'h20, 4'hF, 32'h0, 8'd6);
      @(negedge clock);
      idle_a();
      @(negedge clock); #1;
      checks++;
      if ({d2h.d_valid, d2h.d_data} !== {1'b1, 32'h00AB0000}) begin
         errors++;
         $display("FAIL put_readback: got v%b d%h want 00ab0000",
                  d2h.d_valid, d2h.d_data);
      end
   endtask

   task automatic test_back_to_back();
      h2d.d_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clock);
               drive_a(GET, 2'd2, 32'h100 + 32'(4*i), 4'hF, 32'h0,
                       8'(i + 16));
               #1;
               checks++;
               if ({d2h.a_ready, req_o} !== 2'b11) begin
                  errors++;
                  $display("FAIL b2b_accept[%0d]: got %b want 11",
                           i, {d2h.a_ready, req_o});
               end
            end
            @(negedge clock);
            idle_a();
         end
         begin
            int n = 0;
            int first = -1;
            int last = -1;
            for (int c = 0; c < 20; c++) begin
               @(negedge clock); #2;
               if (d2h.d_valid === 1'b1) begin
                  checks++;
                  if ({d2h.d_source, d2h.d_data} !==
                      {8'(n + 16), 32'h10000000 + 32'(n)}) begin
                     errors++;
                     $display("FAIL b2b_rsp[%0d]: got s%0d d%h",
                              n, d2h.d_source, d2h.d_data);
                  end
                  if (n == 0) first = c;
                  last = c;
                  n++;
               end
            end
            checks++;
            if (n !== 8 || (last - first) !== 7) begin
               errors++;
               $display("FAIL b2b_count: got %0d over %0d cycles want 8 over 7",
                        n, last - first);
            end
         end
      join
   endtask

   task automatic test_stall();
      int k = 0;
      h2d.d_ready = 1'b0;
      repeat (6) begin
         @(negedge clock);
         drive_a(GET, 2'd2, 32'h140 + 32'(4*k), 4'hF, 32'h0, 8'(10 + k));
         #1;
         if (d2h.a_ready) k++;
      end
      checks++;
      if (k !== 3) begin
         errors++;
         $display("FAIL stall_accepted: got %0d want 3", k);
      end
      checks++;
      if ({d2h.a_ready, d2h.d_valid, d2h.d_source} !==
          {1'b0, 1'b1, 8'd10}) begin
         errors++;
         $display("FAIL stall_state: got r%b v%b s%0d want r0 v1 s10",
                  d2h.a_ready, d2h.d_valid, d2h.d_source);
      end
      fork
         begin
            for (int c = 0; c < 25 && k < 5; c++) begin
               @(negedge clock);
               drive_a(GET, 2'd2, 32'h140 + 32'(4*k), 4'hF, 32'h0,
                       8'(10 + k));
               #1;
               if (c == 0) begin
                  checks++;
                  if (d2h.a_ready !== 1'b0) begin
                     errors++;
                     $display("FAIL stall_full: got %b want 0", d2h.a_ready);
                  end
               end
               if (c == 1) begin
                  checks++;
                  if (d2h.a_ready !== 1'b1) begin
                     errors++;
                     $display("FAIL stall_reassert: got %b want 1",
                              d2h.a_ready);
                  end
               end
               if (d2h.a_ready) k++;
            end
            @(negedge clock);
            idle_a();
         end
         begin
            int n = 0;
            for (int c = 0; c < 25; c++) begin
               @(negedge clock);
               if (c == 0) h2d.d_ready = 1'b1;
               #2;
               if (d2h.d_valid === 1'b1) begin
                  checks++;
                  if ({d2h.d_source, d2h.d_data} !==
                      {8'(10 + n), 32'h50000000 + 32'(n)}) begin
                     errors++;
                     $display("FAIL stall_rsp[%0d]: got s%0d d%h",
                              n, d2h.d_source, d2h.d_data);
                  end
                  n++;
               end
            end
            checks++;
            if (n !== 5) begin
               errors++;
               $display("FAIL stall_rsp_count: got %0d want 5", n);
            end
         end
      join
      checks++;
      if (k !== 5) begin
         errors++;
         $display("FAIL stall_total: got %0d want 5", k);
      end
   endtask

   task automatic test_illegal();
      vec_t v [6];
      v[0] = '{3'd2,        2'd2, 32'h0,    4'hF, 1'b1};
      v[1] = '{GET,         2'd2, 32'h2,    4'hF, 1'b1};
      v[2] = '{PUT_FULL,    2'd2, 32'h0,    4'h7, 1'b1};
      v[3] = '{PUT_PARTIAL, 2'd1, 32'h0,    4'h4, 1'b1};
      v[4] = '{GET,         2'd3, 32'h0,    4'hF, 1'b1};
      v[5] = '{PUT_FULL,    2'd1, 32'h1002, 4'hC, 1'b0};
      h2d.d_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         drive_a(v[i].op, v[i].sz, v[i].ad, v[i].mk, 32'h0, 8'(32 + i));
         #1;
         checks++;
         if ({d2h.a_ready, req_o} !== {1'b1, ~v[i].err}) begin
            errors++;
            $display("FAIL illegal_req[%0d]: got %b want %b",
                     i, {d2h.a_ready, req_o}, {1'b1, ~v[i].err});
         end
         @(negedge clock);
         idle_a();
         @(negedge clock); #1;
         checks++;
         if ({d2h.d_valid, d2h.d_error, d2h.d_source, d2h.d_data} !==
             {1'b1, v[i].err, 8'(32 + i), 32'h0}) begin
            errors++;
            $display("FAIL illegal_rsp[%0d]: got v%b e%b s%0d d%h want e%b",
                     i, d2h.d_valid, d2h.d_error, d2h.d_source,
                     d2h.d_data, v[i].err);
         end
      end
   endtask

   task automatic test_addr_check();
      @(negedge clock);
      drive_a(GET, 2'd2, 32'h80000000, 4'hF, 32'h0, 8'd40);
      #1;
      checks++;
`ifdef TLUL_DEVICE_ADDR_CHECK_EN
      if (req_o !== 1'b0) begin
         errors++;
         $display("FAIL addr_req: got %b want 0", req_o);
      end
`else
      if ({req_o, addr_o} !== {1'b1, 12'd0}) begin
         errors++;
         $display("FAIL addr_req: got %h want %h",
                  {req_o, addr_o}, {1'b1, 12'd0});
      end
`endif
      @(negedge clock);
      idle_a();
      @(negedge clock); #1;
      checks++;
`ifdef TLUL_DEVICE_ADDR_CHECK_EN
      if ({d2h.d_valid, d2h.d_error, d2h.d_data} !==
          {1'b1, 1'b1, 32'h0}) begin
`else
      if ({d2h.d_valid, d2h.d_error, d2h.d_data} !==
          {1'b1, 1'b0, 32'hCAFEF00D}) begin
`endif
         errors++;
         $display("FAIL addr_rsp: got v%b e%b d%h",
                  d2h.d_valid, d2h.d_error, d2h.d_data);
      end
   endtask

   task automatic test_mem_err();
      @(negedge clock);
      drive_a(GET, 2'd2, 32'h3FFC, 4'hF, 32'h0, 8'd41);
      @(negedge clock);
      idle_a();
      @(negedge clock); #1;
      checks++;
      if ({d2h.d_valid, d2h.d_opcode, d2h.d_error, d2h.d_data} !==
          {1'b1, 3'd1, 1'b1, 32'h0BADF00D}) begin
         errors++;
         $display("FAIL mem_err: got v%b op%0d e%b d%h",
                  d2h.d_valid, d2h.d_opcode, d2h.d_error, d2h.d_data);
      end
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      h2d.d_ready = 1'b1;
      @(negedge clock);
      drive_a(GET, 2'd2, 32'h10, 4'hF, 32'h0, 8'd7);
      #1;
      checks++;
      if (req_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_req: got %b want 1", req_o);
      end
      @(negedge clock);
      idle_a();
      reset = 1'b1;
      #1;
      checks++;
      if (d2h.a_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_aready_low: got %b want 0", d2h.a_ready);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({d2h.a_ready, d2h.d_valid} !== 2'b10) begin
         errors++;
         $display("FAIL rstmid_release: got %b want 10",
                  {d2h.a_ready, d2h.d_valid});
      end
      repeat (4) begin
         @(negedge clock); #1;
         if (d2h.d_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_dropped: got d_valid %b want 0", seen);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[0]     = 32'hCAFEF00D;
      mem[4]     = 32'hDEADBEEF;
      mem[12'hFFF] = 32'h0BADF00D;
      for (int i = 0; i < 8; i++) mem[12'h40 + i] = 32'h10000000 + 32'(i);
      for (int i = 0; i < 5; i++) mem[12'h50 + i] = 32'h50000000 + 32'(i);
      h2d = '0;
      test_reset();
      test_get();
      test_put_partial();
      test_back_to_back();
      test_stall();
      test_illegal();
      test_addr_check();
      test_mem_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
